clock_set_ctrl: RTL and testbench

//  Front-panel edit controller for the decade clock/calendar datapath. Debounces the three

---
 rtl/clock_set_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// Front-panel edit controller: button debounce, RUN/edit-field FSM, inc/dec strobes, blink mask.
// Optional macro AUTOREPEAT_EN adds held-button auto-repeat of inc/dec strobes.
module clock_set_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned BLINK_CYCLES    = 12_500_000,
    parameter int unsigned TIMEOUT_S       = 30
`ifdef AUTOREPEAT_EN
   ,parameter int unsigned REPEAT_DELAY    = 25_000_000,
    parameter int unsigned REPEAT_PERIOD   = 5_000_000
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1s,
    input  logic       sw_mode,
    input  logic       butt_increase,
    input  logic       butt_decrease,
    input  logic       butt_change,
    output logic       run_en,
    output logic [2:0] field_sel,
    output logic       inc_pulse,
    output logic       dec_pulse,
    output logic       view_cal,
    output logic [7:0] blink_mask
);

    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned BL_W   = $clog2(BLINK_CYCLES + 1);
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_S + 1);
    localparam logic [DB_W-1:0]   DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [BL_W-1:0]   BL_LAST    = BL_W'(BLINK_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_S);

    // Encoding matches the field_sel code so the state drives it directly.
    typedef enum logic [2:0] {
        S_RUN   = 3'd0,
        S_HOUR  = 3'd1,
        S_MIN   = 3'd2,
        S_SEC   = 3'd3,
        S_DAY   = 3'd4,
        S_MONTH = 3'd5,
        S_YEAR  = 3'd6
    } state_t;

    state_t state_q, state_d;

    logic [2:0]      raw_n, sync1_n, sync2_n, accepted, press_evt;
    logic [DB_W-1:0] db_cnt [3];
    logic            evt_inc, evt_dec, evt_chg;

    logic              edit, state_change, inc_d, dec_d, blink_clr, idle_clr;
    logic [BL_W-1:0]   blink_cnt;
    logic              blink_phase;
    logic [IDLE_W-1:0] idle_cnt;

`ifdef AUTOREPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_FIRST_LAST = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_NEXT_LAST  = REP_W'(REPEAT_PERIOD - 1);

    logic             held_inc, held_dec, rep_armed, rep_first, rep_fire, press_strobe;
    logic [REP_W-1:0] rep_cnt;
`endif

    // Index 0 = increase, 1 = decrease, 2 = change; buttons are active-low.
    assign raw_n   = {butt_change, butt_decrease, butt_increase};
    assign evt_inc = press_evt[0];
    assign evt_dec = press_evt[1];
    assign evt_chg = press_evt[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_n   <= '1;
            sync2_n   <= '1;
            accepted  <= '0;
            press_evt <= '0;
            for (int unsigned i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            sync1_n <= raw_n;
            sync2_n <= sync1_n;
            for (int unsigned i = 0; i < 3; i++) begin
                press_evt[i] <= 1'b0;
                if (~sync2_n[i] == accepted[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_cnt[i]    <= '0;
                    accepted[i]  <= ~accepted[i];
                    press_evt[i] <= ~accepted[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_RUN;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        inc_d   = 1'b0;
        dec_d   = 1'b0;
        edit    = (state_q != S_RUN);
        if (edit && idle_cnt == IDLE_LIMIT) begin
            state_d = S_RUN;
        end else if (evt_chg) begin
            state_d = (state_q == S_YEAR) ? S_RUN : state_t'(state_q + 3'd1);
        end else if (edit) begin
            if (evt_inc && !evt_dec) begin
                inc_d = 1'b1;
            end else if (evt_dec && !evt_inc) begin
                dec_d = 1'b1;
            end
`ifdef AUTOREPEAT_EN
            else if (rep_fire) begin
                inc_d = held_inc;
                dec_d = held_dec;
            end
`endif
        end
        state_change = (state_d != state_q);
        blink_clr    = state_change | inc_d | dec_d | ~edit;
        idle_clr     = state_change | (|press_evt) | ~edit;
`ifdef AUTOREPEAT_EN
        idle_clr     = idle_clr | rep_fire;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inc_pulse   <= 1'b0;
            dec_pulse   <= 1'b0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            idle_cnt    <= '0;
        end else begin
            inc_pulse <= inc_d;
            dec_pulse <= dec_d;
            if (blink_clr) begin
                blink_cnt   <= '0;
                blink_phase <= 1'b0;
            end else if (blink_cnt == BL_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
            if (idle_clr)                                idle_cnt <= '0;
            else if (tick_1s && idle_cnt != IDLE_LIMIT)  idle_cnt <= idle_cnt + 1'b1;
        end
    end

`ifdef AUTOREPEAT_EN
    // Repeat timing restarts from the press strobe and from each repeat strobe.
    assign held_inc     = accepted[0] & ~accepted[1];
    assign held_dec     = accepted[1] & ~accepted[0];
    assign press_strobe = (evt_inc ^ evt_dec) & (inc_d | dec_d);
    assign rep_fire     = rep_armed && (held_inc || held_dec) &&
                          (rep_cnt == (rep_first ? REP_FIRST_LAST : REP_NEXT_LAST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_armed <= 1'b0;
            rep_first <= 1'b0;
            rep_cnt   <= '0;
        end else if (!edit || state_change || evt_chg || !(held_inc || held_dec)) begin
            rep_armed <= 1'b0;
            rep_first <= 1'b0;
            rep_cnt   <= '0;
        end else if (press_strobe) begin
            rep_armed <= 1'b1;
            rep_first <= 1'b1;
            rep_cnt   <= '0;
        end else if (rep_fire) begin
            rep_first <= 1'b0;
            rep_cnt   <= '0;
        end else if (rep_armed) begin
            rep_cnt <= rep_cnt + 1'b1;
        end
    end
`endif

    assign run_en    = (state_q == S_RUN);
    assign field_sel = state_q;

    always_comb begin
        view_cal   = 1'b0;
        blink_mask = '0;
        case (state_q)
            S_RUN:                  view_cal = sw_mode;
            S_DAY, S_MONTH, S_YEAR: view_cal = 1'b1;
            default:                view_cal = 1'b0;
        endcase
        if (blink_phase) begin
            case (state_q)
                S_HOUR, S_DAY:  blink_mask = 8'hC0;
                S_MIN, S_MONTH: blink_mask = 8'h30;
                S_SEC:          blink_mask = 8'h0C;
                S_YEAR:         blink_mask = 8'h0F;
                default:        blink_mask = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl against a field/count reference model.
module tb_clock_set_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_1s = 1'b0;
    logic       sw_mode = 1'b0;
    logic       butt_increase = 1'b1;
    logic       butt_decrease = 1'b1;
    logic       butt_change = 1'b1;
    logic       run_en, inc_pulse, dec_pulse, view_cal;
    logic [2:0] field_sel;
    logic [7:0] blink_mask;

    always #5 clk = ~clk;

    clock_set_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .BLINK_CYCLES   (8),
        .TIMEOUT_S      (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick_1s      (tick_1s),
        .sw_mode      (sw_mode),
        .butt_increase(butt_increase),
        .butt_decrease(butt_decrease),
        .butt_change  (butt_change),
        .run_en       (run_en),
        .field_sel    (field_sel),
        .inc_pulse    (inc_pulse),
        .dec_pulse    (dec_pulse),
        .view_cal     (view_cal),
        .blink_mask   (blink_mask)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int n_inc_seen = 0, n_dec_seen = 0, n_both = 0;
    int exp_inc = 0, exp_dec = 0;
    int mf = 0;   // model: current field (0 = RUN)

    always @(negedge clk) begin
        if (inc_pulse === 1'b1) n_inc_seen++;
        if (dec_pulse === 1'b1) n_dec_seen++;
        if (inc_pulse === 1'b1 && dec_pulse === 1'b1) n_both++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mask_of(input int f);
        case (f)
            1, 4:    return 8'hC0;
            2, 5:    return 8'h30;
            3:       return 8'h0C;
            6:       return 8'h0F;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic view_of(input int f, input logic sw);
        return (f == 0) ? sw : (f >= 4);
    endfunction

    task automatic check_status(input string tag);
        chk({tag, ".field"}, 32'(field_sel), 32'(mf));
        chk({tag, ".run_en"}, 32'(run_en), 32'(mf == 0));
        chk({tag, ".view"}, 32'(view_cal), 32'(view_of(mf, sw_mode)));
    endtask

    // b: 0 inc, 1 dec, 2 change, 3 inc+dec, 4 change+inc; held h cycles then released.
    task automatic press(input int b, input int h);
        case (b)
            0: butt_increase = 1'b0;
            1: butt_decrease = 1'b0;
            2: butt_change   = 1'b0;
            3: begin butt_increase = 1'b0; butt_decrease = 1'b0; end
            default: begin butt_change = 1'b0; butt_increase = 1'b0; end
        endcase
        repeat (h) @(negedge clk);
        butt_increase = 1'b1;
        butt_decrease = 1'b1;
        butt_change   = 1'b1;
        repeat (8) @(negedge clk);
        case (b)
            0: if (mf != 0) exp_inc++;
            1: if (mf != 0) exp_dec++;
            2, 4: mf = (mf + 1) % 7;
            default: ;
        endcase
    endtask

    task automatic tick_gap(input int gap);
        tick_1s = 1'b1;
        @(negedge clk);
        tick_1s = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        int n;
        // Reset state
        repeat (2) @(negedge clk);
        check_status("reset");
        chk("reset.mask", 32'(blink_mask), 32'h0);
        chk("reset.inc", 32'(inc_pulse), 32'h0);
        chk("reset.dec", 32'(dec_pulse), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        sw_mode = 1'b1;
        #1 chk("run.view_sw1", 32'(view_cal), 32'h1);
        sw_mode = 1'b0;
        #1 chk("run.view_sw0", 32'(view_cal), 32'h0);

        // Glitch on change: too short to be accepted
        @(negedge clk);
        butt_change = 1'b0;
        repeat (2) @(negedge clk);
        butt_change = 1'b1;
        repeat (10) @(negedge clk);
        check_status("glitch");

        // Held change: HOUR exactly 7 clocks after the raw edge
        butt_change = 1'b0;
        repeat (6) @(negedge clk);
        chk("chg_lat.k6", 32'(field_sel), 32'h0);
        @(negedge clk);
        mf = 1;
        check_status("chg_lat.k7");
        butt_change = 1'b1;
        repeat (8) @(negedge clk);

        // MIN: single inc, strobe timing and blink pattern
        press(2, 7);
        check_status("to_min");
        butt_increase = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 8) butt_increase = 1'b1;
            if (k >= 6 && k <= 8) chk("inc_strobe", 32'(inc_pulse), 32'(k == 7));
            if (k >= 7) chk("min_blink", 32'(blink_mask), ((((k - 7) / 8) % 2) == 1) ? 32'h30 : 32'h0);
        end
        exp_inc++;
        repeat (4) @(negedge clk);
        chk("single_inc.count", 32'(n_inc_seen), 32'(exp_inc));

        // Random inc/dec presses in MIN
        n = $urandom_range(2, 5);
        for (int i = 0; i < n; i++) press($urandom_range(0, 1), $urandom_range(7, 10));
        chk("rand.inc_count", 32'(n_inc_seen), 32'(exp_inc));
        chk("rand.dec_count", 32'(n_dec_seen), 32'(exp_dec));
        check_status("rand.field");

        // Walk the remaining fields back to RUN, then a full 7-step cycle
        for (int i = 0; i < 5; i++) press(2, 7);
        check_status("back_to_run");
        for (int i = 0; i < 7; i++) begin
            sw_mode = 1'($urandom_range(0, 1));
            press(2, 7);
            check_status("cycle");
            chk("cycle.mask", 32'(blink_mask), 32'(mask_of(mf)));
        end

        // HOUR: inc+dec together, then change+inc together
        press(2, 7);
        check_status("hour");
        press(3, 7);
        check_status("incdec.field");
        chk("incdec.inc", 32'(n_inc_seen), 32'(exp_inc));
        chk("incdec.dec", 32'(n_dec_seen), 32'(exp_dec));
        press(4, 7);
        check_status("chginc.field");
        chk("chginc.inc", 32'(n_inc_seen), 32'(exp_inc));

        // DAY: idle timeout, with a press clearing the idle count on the way
        press(2, 7);
        press(2, 7);
        check_status("day");
        tick_gap($urandom_range(1, 5));
        tick_gap($urandom_range(1, 5));
        press(0, 7);
        tick_gap($urandom_range(1, 5));
        tick_gap($urandom_range(1, 5));
        check_status("timeout.cleared");
        tick_1s = 1'b1;
        @(negedge clk);
        tick_1s = 1'b0;
        check_status("timeout.k1");
        @(negedge clk);
        mf = 0;
        check_status("timeout.k2");
        chk("timeout.inc", 32'(n_inc_seen), 32'(exp_inc));

        // SEC: reset mid-edit discards the pending strobe
        for (int i = 0; i < 3; i++) press(2, 7);
        check_status("sec");
        butt_increase = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        mf = 0;
        #1;
        check_status("rst_mid");
        chk("rst_mid.mask", 32'(blink_mask), 32'h0);
        chk("rst_mid.inc", 32'(inc_pulse), 32'h0);
        butt_increase = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check_status("after_rst");
        chk("after_rst.inc", 32'(n_inc_seen), 32'(exp_inc));
        chk("never_both", 32'(n_both), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
